// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA timing generator.
// Produces pixel coordinates for an external renderer, takes its RGB332 back
// after PIPE_DEPTH pixel ticks, and drives registered, blank-masked VGA pins
// whose syncs are aligned to that renderer latency. Also provides line/frame
// strobes and a 16-bit completed-frame counter.

module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int CORD_W     = 10,
  parameter int PIPE_DEPTH = 1
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic [7:0]        rgb_in,
  output logic [CORD_W-1:0] sx,
  output logic [CORD_W-1:0] sy,
  output logic              de,
  output logic              line_start,
  output logic              frame_start,
  output logic [15:0]       frame_cnt,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [2:0]        vga_r,
  output logic [2:0]        vga_g,
  output logic [1:0]        vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject timings the counters cannot represent.
  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_timing
    $error("vga_timing_gen: active/porch/sync parameters must all be nonzero");
  end
  if (PIPE_DEPTH < 0 || PIPE_DEPTH > 8) begin : g_bad_depth
    $error("vga_timing_gen: PIPE_DEPTH must be in 0..8");
  end
  if (CORD_W < 1 || CORD_W > 16 ||
      ((H_TOTAL - 1) >> CORD_W) != 0 || ((V_TOTAL - 1) >> CORD_W) != 0) begin : g_bad_width
    $error("vga_timing_gen: CORD_W cannot hold H_TOTAL-1 / V_TOTAL-1");
  end

  localparam logic [CORD_W-1:0] H_LAST   = CORD_W'(H_TOTAL - 1);
  localparam logic [CORD_W-1:0] V_LAST   = CORD_W'(V_TOTAL - 1);
  localparam logic [CORD_W-1:0] H_VIS    = CORD_W'(H_ACTIVE);
  localparam logic [CORD_W-1:0] V_VIS    = CORD_W'(V_ACTIVE);
  localparam logic [CORD_W-1:0] HS_START = CORD_W'(H_ACTIVE + H_FP);
  localparam logic [CORD_W-1:0] HS_END   = CORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CORD_W-1:0] VS_START = CORD_W'(V_ACTIVE + V_FP);
  localparam logic [CORD_W-1:0] VS_END   = CORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // One timing sample travelling down the delay line towards the pins.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0};

  logic [CORD_W-1:0] r_sx;
  logic [CORD_W-1:0] r_sy;
  logic [15:0]       r_frame_cnt;
  logic              w_line_end;
  logic              w_frame_end;
  sync_t             w_raw;
  sync_t             w_dly;
  logic              r_hsync;
  logic              r_vsync;
  logic [7:0]        r_rgb;

  assign w_line_end  = (r_sx == H_LAST);
  assign w_frame_end = w_line_end && (r_sy == V_LAST);

  // Beam position: sx runs across the line, sy steps when sx wraps.
  always_ff @(posedge clk_pix) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (pix_ce) begin
      if (w_line_end) begin
        r_sx <= '0;
        r_sy <= (r_sy == V_LAST) ? '0 : r_sy + CORD_W'(1);
      end else begin
        r_sx <= r_sx + CORD_W'(1);
      end
    end
  end

  // Completed-frame count, bumped on the last pixel of the last line.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (pix_ce && w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Undelayed sync/blanking decode of the current beam position.
  always_comb begin
    // NOTE: the whole struct gets a default first so no path leaves a field
    // unassigned, which would otherwise infer a latch.
    w_raw = SYNC_IDLE;
    if (r_sx >= HS_START && r_sx <= HS_END) w_raw.hs = H_POL;
    if (r_sy >= VS_START && r_sy <= VS_END) w_raw.vs = V_POL;
    w_raw.de = (r_sx < H_VIS) && (r_sy < V_VIS);
  end

  if (PIPE_DEPTH == 0) begin : g_no_pipe
    assign w_dly = w_raw;
  end else begin : g_pipe
    sync_t r_pipe [PIPE_DEPTH];

    // Delay line matching the renderer latency, advancing on pixel ticks.
    always_ff @(posedge clk_pix) begin
      // NOTE: this small register array is reset explicitly because its
      // contents reach the sync pins; a stale stage would glitch the monitor.
      if (rst) begin
        for (int i = 0; i < PIPE_DEPTH; i++) r_pipe[i] <= SYNC_IDLE;
      end else if (pix_ce) begin
        r_pipe[0] <= w_raw;
        for (int i = 1; i < PIPE_DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign w_dly = r_pipe[PIPE_DEPTH-1];
  end

  // Pin register: aligned syncs and colour forced to black outside the picture.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_hsync <= ~H_POL;
      r_vsync <= ~V_POL;
      r_rgb   <= '0;
    end else if (pix_ce) begin
      r_hsync <= w_dly.hs;
      r_vsync <= w_dly.vs;
      r_rgb   <= w_dly.de ? rgb_in : 8'h00;
    end
  end

  assign sx          = r_sx;
  assign sy          = r_sy;
  assign de          = w_raw.de;
  assign line_start  = pix_ce && (r_sx == '0);
  assign frame_start = pix_ce && (r_sx == '0) && (r_sy == '0);
  assign frame_cnt   = r_frame_cnt;
  assign vga_hsync   = r_hsync;
  assign vga_vsync   = r_vsync;
  assign {vga_r, vga_g, vga_b} = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three configurations driven by shared random
// stimulus, each compared every cycle against an arithmetic reference model
// that derives beam position and pin values from the number of pixel ticks
// elapsed since reset.

module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit hp, vp;
    int d;
  } cfg_t;

  logic       clk_pix = 1'b0;
  logic       rst;
  logic       pix_ce;
  logic [7:0] rgb_in;

  always #5 clk_pix = ~clk_pix;

  // A: tiny active-high timing, 3-stage renderer latency.
  logic [3:0]  a_sx, a_sy;
  logic        a_de, a_ls, a_fs, a_hs, a_vs;
  logic [15:0] a_fc;
  logic [2:0]  a_r, a_g;
  logic [1:0]  a_b;
  // B: full-width lines, tiny frame, direct (no) delay line.
  logic [9:0]  b_sx, b_sy;
  logic        b_de, b_ls, b_fs, b_hs, b_vs;
  logic [15:0] b_fc;
  logic [2:0]  b_r, b_g;
  logic [1:0]  b_b;
  // C: default 640x480 timing.
  logic [9:0]  c_sx, c_sy;
  logic        c_de, c_ls, c_fs, c_hs, c_vs;
  logic [15:0] c_fc;
  logic [2:0]  c_r, c_g;
  logic [1:0]  c_b;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CORD_W(4), .PIPE_DEPTH(3)
  ) u_a (
    .clk_pix(clk_pix), .rst(rst), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .sx(a_sx), .sy(a_sy), .de(a_de), .line_start(a_ls), .frame_start(a_fs),
    .frame_cnt(a_fc), .vga_hsync(a_hs), .vga_vsync(a_vs),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CORD_W(10), .PIPE_DEPTH(0)
  ) u_b (
    .clk_pix(clk_pix), .rst(rst), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .sx(b_sx), .sy(b_sy), .de(b_de), .line_start(b_ls), .frame_start(b_fs),
    .frame_cnt(b_fc), .vga_hsync(b_hs), .vga_vsync(b_vs),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
  );

  vga_timing_gen u_c (
    .clk_pix(clk_pix), .rst(rst), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .sx(c_sx), .sy(c_sy), .de(c_de), .line_start(c_ls), .frame_start(c_fs),
    .frame_cnt(c_fc), .vga_hsync(c_hs), .vga_vsync(c_vs),
    .vga_r(c_r), .vga_g(c_g), .vga_b(c_b)
  );

  int   errors = 0;
  int   checks = 0;
  int   n      = 0;      // pixel ticks since the last reset edge
  logic [7:0] hist[$];   // rgb_in seen at each of those ticks
  cfg_t cfg_a, cfg_b, cfg_c;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h (tick %0d)", tag, observed, expected, n);
      end
  endtask

  // Reference: position is ticks mod line/frame length; pins show the sample
  // taken PIPE_DEPTH+1 ticks ago, with colour from the most recent tick.
  task automatic check_dut(input string nm, input cfg_t c,
                           input logic [15:0] osx, input logic [15:0] osy,
                           input logic ode, input logic ols, input logic ofs,
                           input logic [15:0] ofc, input logic ohs, input logic ovs,
                           input logic [7:0] orgb);
    int ht, vt, x, y, m, mx, my;
    logic ehs, evs;
    logic [7:0] ergb;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    x  = n % ht;
    y  = (n / ht) % vt;
    check({nm, ".sx"}, 32'(osx), x);
    check({nm, ".sy"}, 32'(osy), y);
    check({nm, ".de"}, 32'(ode), 32'(x < c.ha && y < c.va));
    check({nm, ".line_start"}, 32'(ols), 32'(pix_ce && x == 0));
    check({nm, ".frame_start"}, 32'(ofs), 32'(pix_ce && x == 0 && y == 0));
    check({nm, ".frame_cnt"}, 32'(ofc), (n / (ht * vt)) % 65536);
    m = n - 1 - c.d;
    if (m < 0) begin
      ehs  = ~c.hp;
      evs  = ~c.vp;
      ergb = 8'h00;
    end else begin
      mx   = m % ht;
      my   = (m / ht) % vt;
      ehs  = (mx >= c.ha + c.hf && mx < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
      evs  = (my >= c.va + c.vf && my < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
      ergb = (mx < c.ha && my < c.va) ? hist[n-1] : 8'h00;
    end
    check({nm, ".hsync"}, 32'(ohs), 32'(ehs));
    check({nm, ".vsync"}, 32'(ovs), 32'(evs));
    check({nm, ".rgb"}, 32'(orgb), 32'(ergb));
  endtask

  // Apply one cycle of inputs, check mid-cycle, then advance the model at the edge.
  task automatic step(input logic r, input logic ce, input logic [7:0] v);
    rst    = r;
    pix_ce = ce;
    rgb_in = v;
    @(negedge clk_pix);
    check_dut("A", cfg_a, 16'(a_sx), 16'(a_sy), a_de, a_ls, a_fs, a_fc, a_hs, a_vs, {a_r, a_g, a_b});
    check_dut("B", cfg_b, 16'(b_sx), 16'(b_sy), b_de, b_ls, b_fs, b_fc, b_hs, b_vs, {b_r, b_g, b_b});
    check_dut("C", cfg_c, 16'(c_sx), 16'(c_sy), c_de, c_ls, c_fs, c_fc, c_hs, c_vs, {c_r, c_g, c_b});
    @(posedge clk_pix);
    if (r) begin
      n = 0;
      hist.delete();
    end else if (ce) begin
      hist.push_back(v);
      n++;
    end
    #1;
  endtask

  initial begin
    cfg_a = '{ha: 8,   hf: 1,  hs: 2,  hb: 1,  va: 4,   vf: 1,  vs: 1, vb: 1,
              hp: 1'b1, vp: 1'b1, d: 3};
    cfg_b = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 4,   vf: 1,  vs: 1, vb: 1,
              hp: 1'b0, vp: 1'b0, d: 0};
    cfg_c = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
              hp: 1'b0, vp: 1'b0, d: 1};

    // Reset for two cycles; from the first reset edge on, everything is defined.
    rst    = 1'b1;
    pix_ce = 1'b1;
    rgb_in = 8'h00;
    @(posedge clk_pix);
    #1;
    step(1'b1, 1'b1, 8'h00);

    // Reset levels: inactive syncs follow polarity, colour black.
    check("A.rst_hsync", 32'(a_hs), 32'd0);
    check("A.rst_vsync", 32'(a_vs), 32'd0);
    check("C.rst_hsync", 32'(c_hs), 32'd1);
    check("C.rst_vsync", 32'(c_vs), 32'd1);
    check("C.rst_rgb", 32'({c_r, c_g, c_b}), 32'd0);

    // Free-running pixel clock with random colour.
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1, 8'($urandom));

    // Quarter-rate pixel enable: 1,0,0,0.
    for (int i = 0; i < 2000; i++) step(1'b0, (i % 4) == 0, 8'($urandom));

    // Random enable, long enough for B to complete a frame.
    for (int i = 0; i < 6000; i++) step(1'b0, ($urandom_range(9, 0) < 7), 8'($urandom));

    // Directed mid-line reset, then the first tick must raise frame_start.
    step(1'b1, 1'b1, 8'hFF);
    check("C.post_rst_sx", 32'(c_sx), 32'd0);
    check("C.post_rst_fc", 32'(c_fc), 32'd0);
    check("C.post_rst_fs", 32'(c_fs), 32'd1);

    // Random enable with occasional mid-frame resets.
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(199, 0) == 0), ($urandom_range(9, 0) < 6), 8'($urandom));

    // Constant white from the renderer, to expose blanking masks clearly.
    for (int i = 0; i < 1200; i++) step(1'b0, 1'b1, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
